// File: rtl/pc_unit_if.sv
// Request/response bundle between the fetch controller and pc_unit.
// The master drives redirect requests; the slave (pc_unit) returns pc and RAS status.
interface pc_unit_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             stall;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_pc;
  logic             branch_valid;
  logic [XLEN-1:0]  branch_pc;
  logic             branch_is_call;
  logic             ret_valid;
  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] ras_count;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, trap_valid, trap_pc, branch_valid, branch_pc, branch_is_call, ret_valid,
    input  pc, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, trap_valid, trap_pc, branch_valid, branch_pc, branch_is_call, ret_valid,
    output pc, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with trap > stall > branch > return > sequential priority
// and a circular return-address stack that drops its oldest entry when full.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC_BYTES    = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input logic        clk,
  input logic        rst,
  pc_unit_if.slave   bus
);
  localparam int              IDX_W      = $clog2(RAS_DEPTH);
  localparam int              CNT_W      = IDX_W + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INC_BYTES - 1));
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(RAS_DEPTH);

  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] x);
    return x & ALIGN_MASK;
  endfunction

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [IDX_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push_en;
  logic [XLEN-1:0]  seq;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];

  assign seq = pc_q + XLEN'(INC_BYTES);

  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    push_en = 1'b0;
    if (bus.trap_valid) begin
      pc_d  = align(bus.trap_pc);
      cnt_d = '0;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.branch_valid) begin
      pc_d = align(bus.branch_pc);
      if (bus.branch_is_call) begin
        // When full, advancing top lands on the oldest slot and overwrites it.
        push_en = 1'b1;
        top_d   = top_q + IDX_W'(1);
        if (cnt_q == FULL) ovf_d = 1'b1;
        else               cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (bus.ret_valid) begin
      if (cnt_q != '0) begin
        pc_d  = ras_q[top_q];
        top_d = top_q - IDX_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        pc_d  = seq;
        unf_d = 1'b1;
      end
    end else begin
      pc_d = seq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage carries no reset; only the count decides which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push_en) ras_q[top_d] <= align(seq);
  end

  assign bus.pc            = pc_q;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed walk through the main scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_pc_unit;
  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0000_1000;
  localparam int          INC   = 4;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) bus ();

  pc_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .INC_BYTES(INC), .RAS_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_unf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] al(input logic [31:0] x);
    return x & ~32'(INC - 1);
  endfunction

  task automatic model();
    logic [31:0] seq;
    seq = m_pc + 32'(INC);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (rst) begin
      m_pc = RV;
      m_ras.delete();
    end else if (bus.trap_valid) begin
      m_pc = al(bus.trap_pc);
      m_ras.delete();
    end else if (bus.stall) begin
      m_pc = m_pc;
    end else if (bus.branch_valid) begin
      if (bus.branch_is_call) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(al(seq));
      end
      m_pc = al(bus.branch_pc);
    end else if (bus.ret_valid) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc  = seq;
        m_unf = 1'b1;
      end
    end else begin
      m_pc = seq;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model();
    chk("pc", 64'(bus.pc), 64'(m_pc));
    chk("ras_count", 64'(bus.ras_count), 64'(m_ras.size()));
    chk("ras_overflow", 64'(bus.ras_overflow), 64'(m_ovf));
    chk("ras_underflow", 64'(bus.ras_underflow), 64'(m_unf));
  endtask

  task automatic idle();
    bus.stall = 0; bus.trap_valid = 0; bus.branch_valid = 0;
    bus.branch_is_call = 0; bus.ret_valid = 0; rst = 0;
  endtask

  task automatic call_to(input logic [31:0] tgt);
    idle();
    bus.branch_valid = 1; bus.branch_is_call = 1; bus.branch_pc = tgt;
    step();
  endtask

  task automatic ret1();
    idle();
    bus.ret_valid = 1;
    step();
  endtask

  initial begin
    m_pc = 32'hDEAD_BEEF;
    m_ovf = 0; m_unf = 0;
    idle();
    bus.trap_pc = '0; bus.branch_pc = '0;

    // reset and sequential advance
    rst = 1; step();
    chk("reset_pc", 64'(bus.pc), 64'h1000);
    chk("reset_cnt", 64'(bus.ras_count), 64'd0);
    idle(); step(); step();
    chk("seq_1008", 64'(bus.pc), 64'h1008);
    call_to(32'h2003);
    chk("call_pc", 64'(bus.pc), 64'h2000);
    chk("call_cnt", 64'(bus.ras_count), 64'd1);
    ret1();
    chk("ret_pc", 64'(bus.pc), 64'h100C);
    idle(); step();
    chk("seq_1010", 64'(bus.pc), 64'h1010);

    // stall blocks branch, trap overrides stall
    bus.stall = 1; bus.branch_valid = 1; bus.branch_pc = 32'h3000;
    repeat (3) step();
    chk("stall_pc", 64'(bus.pc), 64'h1010);
    bus.trap_valid = 1; bus.trap_pc = 32'h80;
    step();
    chk("trap_pc", 64'(bus.pc), 64'h80);
    chk("trap_cnt", 64'(bus.ras_count), 64'd0);

    // overflow then drain into underflow
    idle(); bus.branch_valid = 1; bus.branch_pc = 32'h100; step();
    for (int i = 2; i <= 6; i++) begin
      call_to(32'(i) << 8);
      chk("ovf_pulse", 64'(bus.ras_overflow), 64'(i == 6));
    end
    chk("ovf_cnt", 64'(bus.ras_count), 64'd4);
    for (int i = 5; i >= 2; i--) begin
      ret1();
      chk("ret_chain", 64'(bus.pc), 64'((32'(i) << 8) + 32'h4));
    end
    ret1();
    chk("unf_pulse", 64'(bus.ras_underflow), 64'd1);
    chk("unf_pc", 64'(bus.pc), 64'h208);
    idle(); step();
    chk("unf_clear", 64'(bus.ras_underflow), 64'd0);

    // wrap-around and branch-vs-ret
    bus.branch_valid = 1; bus.branch_pc = 32'hFFFF_FFF8; step();
    idle(); step();
    chk("wrap_fffc", 64'(bus.pc), 64'hFFFF_FFFC);
    step();
    chk("wrap_0", 64'(bus.pc), 64'h0);
    call_to(32'h10);
    idle(); bus.branch_valid = 1; bus.ret_valid = 1; bus.branch_pc = 32'h40; step();
    chk("br_ret_pc", 64'(bus.pc), 64'h40);
    chk("br_ret_cnt", 64'(bus.ras_count), 64'd1);

    // reset during stall with a partly full stack
    call_to(32'h50); call_to(32'h60);
    chk("pre_rst_cnt", 64'(bus.ras_count), 64'd3);
    idle(); bus.stall = 1; rst = 1; step();
    chk("mid_rst_pc", 64'(bus.pc), 64'h1000);
    chk("mid_rst_cnt", 64'(bus.ras_count), 64'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst                = ($urandom_range(0, 49) == 0);
      bus.trap_valid     = ($urandom_range(0, 15) == 0);
      bus.stall          = ($urandom_range(0, 3) == 0);
      bus.branch_valid   = ($urandom_range(0, 3) == 0);
      bus.branch_is_call = $urandom_range(0, 1) == 1;
      bus.ret_valid      = ($urandom_range(0, 2) == 0);
      bus.trap_pc        = $urandom;
      bus.branch_pc      = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
